// File: rtl/fabric_init_pkg.sv
// Shared definitions for the fabric flip-flop initialisation sequencer:
// state encoding, phase-counter width and legal parameter limits.
package fabric_init_pkg;

    localparam int CNT_W    = 8;
    localparam int HOLD_MIN = 1;
    localparam int HOLD_MAX = 255;
    localparam int GAP_MIN  = 1;
    localparam int GAP_MAX  = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_SET_HOLD,
        ST_GAP,
        ST_RUN
    } state_e;

    // Keeps a phase length inside the range the 8-bit counter can express.
    function automatic int clamp_len(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/fabric_init_cnt.sv
// Loadable 8-bit phase down-counter with a zero flag. It stops at zero
// rather than wrapping, so a phase can never be stretched by 256 cycles.
module fabric_init_cnt
    import fabric_init_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fabric_ff_init_seq.sv
// Fabric flip-flop initialisation sequencer. After the configuration chain
// is loaded it holds the global FF reset net for HOLD_CYCLES, waits
// GAP_CYCLES quiet cycles and then enables the fabric clock. A requester in
// RUN can ask for a re-initialisation and is acknowledged with a one-cycle
// init_ack when the fabric is running again.
// Optional feature macro: FABRIC_FF_INIT_SET_PHASE_EN adds a preset phase
// (ff_set) selected by init_set; without it ff_set is tied low and every
// request performs a clear.
module fabric_ff_init_seq
    import fabric_init_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
)
(
    input  logic clk,
    input  logic reset,
    input  logic prog_done,
    input  logic init_req,
    input  logic init_set,
    output logic ff_reset,
    output logic ff_set,
    output logic clk_en,
    output logic init_ack,
    output logic busy
);

    localparam int HOLD_LEN = clamp_len(HOLD_CYCLES, HOLD_MIN, HOLD_MAX);
    localparam int GAP_LEN  = clamp_len(GAP_CYCLES, GAP_MIN, GAP_MAX);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             ack_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             ff_reset_q, clk_en_q, init_ack_q, busy_q;

    fabric_init_cnt u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next state, counter control, pending-request flag and ack generation.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        if (!prog_done) begin
            // Losing the configuration aborts everything, silently.
            state_d   = ST_IDLE;
            pending_d = 1'b0;
            cnt_load  = 1'b1;
            cnt_val   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_RST_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LOAD;
                end
                ST_RST_HOLD, ST_SET_HOLD: begin
                    if (cnt_zero) begin
                        state_d  = ST_GAP;
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        state_d   = ST_RUN;
                        ack_d     = pending_q;
                        pending_d = 1'b0;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        pending_d = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = HOLD_LOAD;
`ifdef FABRIC_FF_INIT_SET_PHASE_EN
                        state_d   = init_set ? ST_SET_HOLD : ST_RST_HOLD;
`else
                        state_d   = ST_RST_HOLD;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, flag and output registers; outputs decode the next state so
    // they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            ff_reset_q <= 1'b1;
            clk_en_q   <= 1'b0;
            init_ack_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ff_reset_q <= (state_d == ST_IDLE) || (state_d == ST_RST_HOLD);
            clk_en_q   <= (state_d == ST_RUN);
            init_ack_q <= ack_d;
            busy_q     <= (state_d != ST_RUN);
        end
    end

`ifdef FABRIC_FF_INIT_SET_PHASE_EN
    logic ff_set_q;

    // Preset net register, active only in the preset hold phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            ff_set_q <= 1'b0;
        end else begin
            ff_set_q <= (state_d == ST_SET_HOLD);
        end
    end

    assign ff_set = ff_set_q;
`else
    logic unused_init_set;
    assign unused_init_set = init_set;
    assign ff_set          = 1'b0;
`endif

    assign ff_reset = ff_reset_q;
    assign clk_en   = clk_en_q;
    assign init_ack = init_ack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fabric_ff_init_seq.sv
// Bench for fabric_ff_init_seq: a default instance (4/2) and a minimum
// phase instance (1/1) share one stimulus stream. The reference model
// tracks, per instance, the edge at which the current sequence started and
// derives each cycle's expected outputs from the elapsed distance.
// Honours FABRIC_FF_INIT_SET_PHASE_EN like the design.
module tb_fabric_ff_init_seq;

`ifdef FABRIC_FF_INIT_SET_PHASE_EN
    localparam bit SET_EN = 1'b1;
`else
    localparam bit SET_EN = 1'b0;
`endif

    localparam int H0 = 4, G0 = 2;
    localparam int H1 = 1, G1 = 1;

    logic clk = 1'b0;
    logic reset, prog_done, init_req, init_set;
    logic ffr0, ffs0, cke0, ack0, bsy0;
    logic ffr1, ffs1, cke1, ack1, bsy1;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // model state per instance
    bit idle_m   [2];
    bit preset_m [2];
    bit req_m    [2];
    int start_m  [2];
    int hold_m   [2];
    int gap_m    [2];

    always #5 clk = ~clk;

    fabric_ff_init_seq #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut0 (
        .clk(clk), .reset(reset), .prog_done(prog_done), .init_req(init_req),
        .init_set(init_set), .ff_reset(ffr0), .ff_set(ffs0), .clk_en(cke0),
        .init_ack(ack0), .busy(bsy0)
    );

    fabric_ff_init_seq #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut1 (
        .clk(clk), .reset(reset), .prog_done(prog_done), .init_req(init_req),
        .init_set(init_set), .ff_reset(ffr1), .ff_set(ffs1), .clk_en(cke1),
        .init_ack(ack1), .busy(bsy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // expected {ff_reset, ff_set, clk_en, init_ack, busy} after edge n
    function automatic logic [4:0] expect_out(input int i, input int n);
        int p;
        if (idle_m[i]) return 5'b10001;
        p = n - start_m[i];
        if (p < hold_m[i]) return preset_m[i] ? 5'b01001 : 5'b10001;
        if (p < hold_m[i] + gap_m[i]) return 5'b00001;
        return {3'b001, (req_m[i] && p == hold_m[i] + gap_m[i]), 1'b0};
    endfunction

    task automatic model_edge(input int n);
        for (int i = 0; i < 2; i++) begin
            if (reset || !prog_done) begin
                idle_m[i] = 1'b1;
            end else if (idle_m[i]) begin
                idle_m[i]   = 1'b0;
                start_m[i]  = n;
                preset_m[i] = 1'b0;
                req_m[i]    = 1'b0;
            end else if ((n - 1 - start_m[i]) >= hold_m[i] + gap_m[i] && init_req) begin
                start_m[i]  = n;
                preset_m[i] = init_set && SET_EN;
                req_m[i]    = 1'b1;
            end
        end
    endtask

    // one clock: model follows the edge, outputs compared 1 time unit later
    task automatic cycle();
        logic [4:0] got0, got1;
        @(posedge clk);
        edge_n++;
        model_edge(edge_n);
        #1;
        got0 = {ffr0, ffs0, cke0, ack0, bsy0};
        got1 = {ffr1, ffs1, cke1, ack1, bsy1};
        check_eq("out_d0", 32'(got0), 32'(expect_out(0, edge_n)));
        check_eq("out_d1", 32'(got1), 32'(expect_out(1, edge_n)));
        check_eq("excl_d0", 32'(ffr0 & ffs0), 32'd0);
        check_eq("excl_d1", 32'(ffr1 & ffs1), 32'd0);
        check_eq("clken_quiet_d0", 32'(cke0 & (ffr0 | ffs0)), 32'd0);
        check_eq("clken_quiet_d1", 32'(cke1 & (ffr1 | ffs1)), 32'd0);
    endtask

    // issue a request on instance 0 and count its phases until the ack
    task automatic request(input bit set_v, input string tag);
        int rcnt = 0, scnt = 0, acks = 0;
        bit seen = 1'b0;
        init_req = 1'b1;
        init_set = set_v;
        for (int k = 0; k < 30 && !seen; k++) begin
            cycle();
            if (ffr0) rcnt++;
            if (ffs0) scnt++;
            if (ack0) begin
                seen = 1'b1;
                acks++;
                init_req = 1'b0;
            end
        end
        init_req = 1'b0;
        check_eq({tag, "_ack_seen"}, 32'(seen), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (ack0) acks++;
        end
        check_eq({tag, "_ack_once"}, 32'(acks), 32'd1);
        check_eq({tag, "_rst_cycles"}, 32'(rcnt), (set_v && SET_EN) ? 32'd0 : 32'd4);
        check_eq({tag, "_set_cycles"}, 32'(scnt), (set_v && SET_EN) ? 32'd4 : 32'd0);
    endtask

    initial begin
        int acks;
        bit seen;
        hold_m[0] = H0; gap_m[0] = G0;
        hold_m[1] = H1; gap_m[1] = G1;
        for (int i = 0; i < 2; i++) begin
            idle_m[i] = 1'b1; preset_m[i] = 1'b0; req_m[i] = 1'b0; start_m[i] = 0;
        end
        reset = 1'b1; prog_done = 1'b0; init_req = 1'b0; init_set = 1'b0;

        // power-up: reset for edges 1-2, prog_done seen at edge 5
        cycle();
        cycle();
        check_eq("rst_state", 32'({ffr0, ffs0, cke0, ack0, bsy0}), 32'b10001);
        reset = 1'b0;
        cycle();
        cycle();
        prog_done = 1'b1;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (ack0) acks++;
        end
        check_eq("pwrup_no_ack", 32'(acks), 32'd0);
        check_eq("pwrup_running", 32'(cke0), 32'd1);

        // clear and preset requests
        request(1'b0, "clr");
        request(1'b1, "pre");

        // abort in the second hold cycle
        for (int k = 0; k < 4; k++) cycle();
        init_req = 1'b1; init_set = 1'b0;
        cycle();
        init_req = 1'b0;
        cycle();
        prog_done = 1'b0;
        cycle();
        check_eq("abort_idle", 32'({ffr0, cke0, ack0}), 32'b100);
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (ack0) acks++;
        end
        check_eq("abort_no_ack", 32'(acks), 32'd0);

        // reset while instance 0 sits in the gap
        prog_done = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            if (!ffr0 && !ffs0 && !cke0) seen = 1'b1;
        end
        check_eq("gap_reached", 32'(seen), 32'd1);
        reset = 1'b1;
        cycle();
        check_eq("gap_rst_d0", 32'({ffr0, ffs0, cke0, ack0, bsy0}), 32'b10001);
        check_eq("gap_rst_d1", 32'({ffr1, ffs1, cke1, ack1, bsy1}), 32'b10001);
        reset = 1'b0;

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            reset     = ($urandom_range(0, 149) == 0);
            prog_done = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) init_req = ~init_req;
            init_set  = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
